mux_n_sel: RTL

MUX_N_SEL -- requirements
Module: mux_n_sel

---
 rtl/mux_n_sel.sv | 114 +++++++++++
 1 files changed

// File: rtl/mux_n_sel.sv
// N-channel valid/ready selector feeding a single registered output slot.
// Round-robin selection is built only when MUX_N_SEL_RR_EN is defined; otherwise fixed select.
module mux_n_sel #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_chan
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_chan_q, out_chan_d;

  logic             fix_vld;
  logic             grant_vld;
  logic [SW-1:0]    grant_idx;
  logic             can_accept;
  logic             xfer;

  // Fixed select only grants an in-range index whose channel is valid.
  always_comb begin
    fix_vld = 1'b0;
    if (int'(sel) < N) fix_vld = in_valid[sel];
  end

`ifdef MUX_N_SEL_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;

  // Scan from the far end back toward ptr so the channel closest to ptr wins.
  always_comb begin
    int c;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr_q) + k;
      if (c >= N) c = c - N;
      if (in_valid[SW'(c)]) begin
        rr_vld = 1'b1;
        rr_idx = SW'(c);
      end
    end
  end

  assign grant_vld = mode ? rr_vld : fix_vld;
  assign grant_idx = mode ? rr_idx : sel;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode) ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant_vld   = fix_vld;
  assign grant_idx   = sel;
`endif

  assign can_accept = !out_valid_q | out_ready;
  assign xfer       = rst_n & grant_vld & can_accept;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  // A transfer reloads the slot even while it drains, so throughput stays at one word per cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
